kb_ctrl: RTL and testbench

- PS/2 keyboard controller; the device slave that fills the KB window of the CPU memory bus, at KB_START, directly after the VGA region.
- Samples the PS/2 clock/data lines, deframes scancodes and queues them in a small FIFO.
- Exposes a 16-bit register interface, same word width and per-cycle strobe style as the cache/LED/VGA slaves.
- The bus FSM issues 16-bit reads/writes to it; a 32-bit read is two consecutive 16-bit accesses at offsets +0, +2.

---
 rtl/kb_pkg.sv | 27 ++
 rtl/ps2_rx.sv | 117 +++++++++++
 rtl/kb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_kb_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared constants, register map and RX FSM states for the PS/2 keyboard controller
package kb_pkg;

    localparam logic [1:0] KB_REG_DATA   = 2'h0;
    localparam logic [1:0] KB_REG_STATUS = 2'h2;

    localparam int ST_OVF_BIT     = 4;
    localparam int ST_PAR_BIT     = 5;
    localparam int ST_FRM_BIT     = 6;
    localparam int DATA_VALID_BIT = 8;

    localparam logic [7:0] KB_PFX_EXT = 8'hE0;
    localparam logic [7:0] KB_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchronisers, falling-edge detect, frame deserialiser and timeout
module ps2_rx
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_push,
    output logic       rx_par_err,
    output logic       rx_frm_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    sync_clk;
    logic [1:0]    sync_data;
    logic          fall;
    logic          bit_in;
    logic          timeout;
    rx_state_t     state, state_nxt;
    logic [7:0]    shift_q, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          par_q, par_nxt;
    logic [TW-1:0] idle_cnt;

    // Two-stage synchronisers; idle PS/2 lines are high, so reset loads ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_clk  <= 2'b11;
            sync_data <= 2'b11;
        end else begin
            sync_clk  <= {sync_clk[0], ps2_clk};
            sync_data <= {sync_data[0], ps2_data};
        end
    end

    assign fall    = sync_clk[1] & ~sync_clk[0];
    assign bit_in  = sync_data[1];
    assign timeout = (idle_cnt == TW'(TIMEOUT_CYCLES));
    assign rx_byte = shift_q;

    // Cycles since the last falling edge; held at zero while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (fall || state == RX_IDLE) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Frame state and shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RX_IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_q   <= par_nxt;
        end
    end

    // Next-state logic; push and error pulses fire on the stop-bit edge
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_q;
        rx_push     = 1'b0;
        rx_par_err  = 1'b0;
        rx_frm_err  = 1'b0;
        if (state != RX_IDLE && !fall && timeout) begin
            state_nxt = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    if (!bit_in) begin
                        state_nxt   = RX_DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_nxt   = {bit_in, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_nxt   = bit_in;
                    state_nxt = RX_STOP;
                end
                RX_STOP: begin
                    if (!bit_in) begin
                        rx_frm_err = 1'b1;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        rx_par_err = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                    state_nxt = RX_IDLE;
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/kb_ctrl.sv
// rtl/kb_ctrl.sv - PS/2 keyboard bus slave: scancode FIFO and registers; option KB_SCANCODE_DECODE_EN
module kb_ctrl
    import kb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kb_en,
    input  logic        kb_wen,
    input  logic [1:0]  kb_addr,
    input  logic [15:0] kb_wdata,
    output logic [15:0] kb_rdata,
    output logic        kb_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef KB_SCANCODE_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    logic [7:0]    rx_byte;
    logic          rx_push, rx_par_err, rx_frm_err;
    logic [1:0]    reg_off;
    logic          data_rd, data_wr, status_rd, status_wr;
    logic          push_req, push, pop, flush, ovf_set;
    logic          empty, full;
    logic [EW-1:0] push_entry, head;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
    logic          ovf_q, par_q, frm_q;
    logic [15:0]   status_word, rdata_nxt;
    logic          unused_bits;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_push    (rx_push),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err)
    );

    assign reg_off     = {kb_addr[1], 1'b0};
    assign data_rd     = kb_en && !kb_wen && reg_off == KB_REG_DATA;
    assign data_wr     = kb_en &&  kb_wen && reg_off == KB_REG_DATA;
    assign status_rd   = kb_en && !kb_wen && reg_off == KB_REG_STATUS;
    assign status_wr   = kb_en &&  kb_wen && reg_off == KB_REG_STATUS;
    assign unused_bits = ^{kb_addr[0], kb_wdata[15:7], kb_wdata[3:0], status_rd};

`ifdef KB_SCANCODE_DECODE_EN
    logic ext_q, brk_q, is_ext, is_brk;

    assign is_ext     = (rx_byte == KB_PFX_EXT);
    assign is_brk     = (rx_byte == KB_PFX_BRK);
    assign push_req   = rx_push && !is_ext && !is_brk;
    assign push_entry = {ext_q, brk_q, rx_byte};

    // Prefix latches: armed by E0/F0, consumed by the next real scancode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (data_wr) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (rx_push) begin
            if (is_ext) begin
                ext_q <= 1'b1;
            end else if (is_brk) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end
`else
    assign push_req   = rx_push;
    assign push_entry = rx_byte;
`endif

    assign flush   = data_wr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push    = push_req && !full && !flush;
    assign ovf_set = push_req && full && !flush;
    assign pop     = data_rd && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[PW-1:0]];

    // Pointer updates; a flush overrides any push or pop in the same cycle
    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + (PW+1)'(1);
            if (pop)  rd_nxt = rd_ptr + (PW+1)'(1);
        end
    end

    // Pointer registers and interrupt, which mirrors non-empty after this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            kb_irq <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            kb_irq <= (wr_nxt != rd_nxt);
        end
    end

    // Queue storage; contents behind the pointers need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_entry;
    end

    // Sticky error flags: a new event outranks a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            par_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set    | (ovf_q & ~(status_wr & kb_wdata[ST_OVF_BIT]));
            par_q <= rx_par_err | (par_q & ~(status_wr & kb_wdata[ST_PAR_BIT]));
            frm_q <= rx_frm_err | (frm_q & ~(status_wr & kb_wdata[ST_FRM_BIT]));
        end
    end

    // Read mux for DATA and STATUS words
    always_comb begin
        status_word             = '0;
        status_word[3:0]        = 4'(count);
        status_word[ST_OVF_BIT] = ovf_q;
        status_word[ST_PAR_BIT] = par_q;
        status_word[ST_FRM_BIT] = frm_q;
        rdata_nxt               = '0;
        if (reg_off == KB_REG_DATA) begin
            if (!empty) begin
                rdata_nxt[7:0]            = head[7:0];
                rdata_nxt[DATA_VALID_BIT] = 1'b1;
`ifdef KB_SCANCODE_DECODE_EN
                rdata_nxt[10:9]           = head[9:8];
`endif
            end
        end else begin
            rdata_nxt = status_word;
        end
    end

    // Read data register, updated only by read accesses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kb_rdata <= '0;
        end else if (kb_en && !kb_wen) begin
            kb_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_kb_ctrl.sv
// tb/tb_kb_ctrl.sv - table-driven self-checking bench for kb_ctrl
module tb_kb_ctrl;

    localparam int TMO  = 300;
    localparam int HALF = 10;

    localparam int OP_FRAME = 0;
    localparam int OP_RD    = 1;
    localparam int OP_WR    = 2;
    localparam int OP_IRQ   = 3;

    typedef struct {
        int          op;
        logic [7:0]  arg;
        logic        bad_par;
        logic        bad_stop;
        logic [15:0] val;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kb_en = 1'b0;
    logic        kb_wen = 1'b0;
    logic [1:0]  kb_addr = 2'd0;
    logic [15:0] kb_wdata = 16'd0;
    logic [15:0] kb_rdata;
    logic        kb_irq;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    kb_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb_en    (kb_en),
        .kb_wen   (kb_wen),
        .kb_addr  (kb_addr),
        .kb_wdata (kb_wdata),
        .kb_rdata (kb_rdata),
        .kb_irq   (kb_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        kb_en = 1'b1; kb_wen = 1'b0; kb_addr = a;
        @(negedge clk);
        kb_en = 1'b0;
        d = kb_rdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        kb_en = 1'b1; kb_wen = 1'b1; kb_addr = a; kb_wdata = d;
        @(negedge clk);
        kb_en = 1'b0; kb_wen = 1'b0;
    endtask

    function automatic void add_frame(input logic [7:0] b, input logic bp, input logic bs);
        vecs.push_back('{OP_FRAME, b, bp, bs, 16'h0000});
    endfunction
    function automatic void add_rd(input logic [7:0] a, input logic [15:0] e);
        vecs.push_back('{OP_RD, a, 1'b0, 1'b0, e});
    endfunction
    function automatic void add_wr(input logic [7:0] a, input logic [15:0] d);
        vecs.push_back('{OP_WR, a, 1'b0, 1'b0, d});
    endfunction
    function automatic void add_irq(input logic e);
        vecs.push_back('{OP_IRQ, 8'h00, 1'b0, 1'b0, {15'd0, e}});
    endfunction

    initial begin
        logic [15:0] rd;

        // single valid frame, then pop and empty read
        add_rd(8'h2, 16'h0000);
        add_frame(8'h1C, 1'b0, 1'b0);
        add_rd(8'h2, 16'h0001);
        add_irq(1'b1);
        add_rd(8'h0, 16'h011C);
        add_rd(8'h0, 16'h0000);
        add_rd(8'h2, 16'h0000);
        add_irq(1'b0);
        // parity error, then clear
        add_frame(8'h1C, 1'b1, 1'b0);
        add_rd(8'h2, 16'h0020);
        add_irq(1'b0);
        add_wr(8'h2, 16'h0020);
        add_rd(8'h2, 16'h0000);
        // framing error, and framing beats parity when both fail
        add_frame(8'h1C, 1'b0, 1'b1);
        add_rd(8'h2, 16'h0040);
        add_wr(8'h2, 16'h0040);
        add_frame(8'h1C, 1'b1, 1'b1);
        add_rd(8'h2, 16'h0040);
        add_wr(8'h2, 16'h0040);
        add_rd(8'h2, 16'h0000);
        // overflow with pointer wrap
        for (int i = 1; i <= 9; i++) add_frame(8'(i), 1'b0, 1'b0);
        add_rd(8'h2, 16'h0018);
        add_irq(1'b1);
        for (int i = 1; i <= 8; i++) add_rd(8'h0, 16'h0100 | 16'(i));
        add_rd(8'h2, 16'h0010);
        add_irq(1'b0);
        add_wr(8'h2, 16'h0010);
        add_rd(8'h2, 16'h0000);
        // flush by DATA write
        add_frame(8'h55, 1'b0, 1'b0);
        add_frame(8'h66, 1'b0, 1'b0);
        add_rd(8'h2, 16'h0002);
        add_wr(8'h0, 16'hFFFF);
        add_rd(8'h2, 16'h0000);
        add_rd(8'h0, 16'h0000);
        add_irq(1'b0);

        #1;
        check("reset_rdata", kb_rdata, 16'h0000);
        check("reset_irq", {15'd0, kb_irq}, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_FRAME: send_frame(vecs[i].arg, vecs[i].bad_par, vecs[i].bad_stop);
                OP_RD: begin
                    bus_read(vecs[i].arg[1:0], rd);
                    check($sformatf("vec%0d_rd%0h", i, vecs[i].arg), rd, vecs[i].val);
                end
                OP_WR: bus_write(vecs[i].arg[1:0], vecs[i].val);
                default: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_irq", i), {15'd0, kb_irq}, vecs[i].val);
                end
            endcase
        end

        // partial frame abandoned by timeout, next frame still good
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        repeat (TMO + 10) @(negedge clk);
        bus_read(2'h2, rd);
        check("tmo_status", rd, 16'h0000);
        send_frame(8'h2A, 1'b0, 1'b0);
        bus_read(2'h0, rd);
        check("tmo_data", rd, 16'h012A);
        bus_read(2'h2, rd);
        check("tmo_status_after", rd, 16'h0000);

        // prefix handling
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
`ifdef KB_SCANCODE_DECODE_EN
        bus_read(2'h0, rd);
        check("pfx_0", rd, 16'h0775);
`else
        bus_read(2'h0, rd);
        check("pfx_0", rd, 16'h01E0);
        bus_read(2'h0, rd);
        check("pfx_1", rd, 16'h01F0);
        bus_read(2'h0, rd);
        check("pfx_2", rd, 16'h0175);
`endif
        bus_read(2'h0, rd);
        check("pfx_empty", rd, 16'h0000);

        // reset in the middle of a frame with entries queued
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        bus_read(2'h2, rd);
        check("rst_pre_status", rd, 16'h0003);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_rdata", kb_rdata, 16'h0000);
        check("rst_irq", {15'd0, kb_irq}, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(2'h2, rd);
        check("rst_post_status", rd, 16'h0000);
        send_frame(8'h33, 1'b0, 1'b0);
        bus_read(2'h0, rd);
        check("rst_post_data", rd, 16'h0133);
        @(negedge clk);
        check("rst_post_irq", {15'd0, kb_irq}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
